fpu_add_seq: RTL and testbench

Sequential floating-point adder for the team's 32-bit format: sign[31], exponent[30:21] (bias 511), fraction[20:0] with hidden 1. It is the responder behind the operand/result interface our benches drive. It accepts one operand pair per start pulse, computes A+B through a fixed-latency pipeline FSM, and returns the result with a 4-bit status code. It runs on the 100 kHz system clock.

---
 rtl/fpu_add_seq.sv | 179 +++++++++++++++++
 tb/tb_fpu_add_seq.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_add_seq.sv
// fpu_add_seq: 7-cycle sequential adder for the 1/10/21 float format (bias 511).
// Define FPU_ROUND_NEAREST_EN for round-to-nearest-even; otherwise results are truncated.
module fpu_add_seq (
    input  logic        clock_100Khz,
    input  logic        reset,
    input  logic        start_in,
    input  logic [31:0] Op_A_in,
    input  logic [31:0] Op_B_in,
    output logic        busy_out,
    output logic        done_out,
    output logic [31:0] data_out,
    output logic [3:0]  status_out
);
    localparam logic [3:0] OVERFLOW = 4'd0, UNDERFLOW = 4'd1, EXACT = 4'd2, INEXACT = 4'd3;

    typedef enum logic [2:0] {IDLE, UNPACK, ALIGN, ADD, NORM, ROUND, DONE} state_t;

    state_t             state_q, state_d;
    logic               busy_q, busy_d, done_q, done_d;
    logic [31:0]        data_q, data_d;
    logic [3:0]         status_q, status_d;
    logic [31:0]        opa_q, opa_d, opb_q, opb_d;
    logic               sgn_q, sgn_d, sub_q, sub_d, inx_q, inx_d, spc_q, spc_d;
    logic [31:0]        spc_data_q, spc_data_d;
    logic [3:0]         spc_st_q, spc_st_d;
    logic signed [11:0] exp_q, exp_d;
    logic [9:0]         dif_q, dif_d;
    logic [24:0]        big_q, big_d, sml_q, sml_d;
    logic [25:0]        acc_q, acc_d;

    logic        a_big;
    logic [31:0] big_op, sml_op;
    logic [49:0] shf;
    logic [4:0]  lz;
    logic        rnd_inc;
    logic [22:0] rnd;

    assign a_big  = opa_q[30:0] >= opb_q[30:0];
    assign big_op = a_big ? opa_q : opb_q;
    assign sml_op = a_big ? opb_q : opa_q;
    assign shf    = {sml_q, 25'b0} >> dif_q[4:0];

`ifdef FPU_ROUND_NEAREST_EN
    assign rnd_inc = acc_q[2] & (acc_q[1] | acc_q[0] | acc_q[3]);
`else
    assign rnd_inc = 1'b0;
`endif
    assign rnd = {1'b0, acc_q[24:3]} + {22'b0, rnd_inc};

    always_comb begin
        lz = 5'd0;
        for (int i = 0; i < 25; i++)
            if (acc_q[i]) lz = 5'(24 - i);
    end

    always_comb begin
        state_d = state_q == IDLE ? (start_in ? UNPACK : IDLE) :
                  state_q == DONE ? IDLE : state_t'(state_q + 3'd1);
    end

    always_comb begin
        busy_d     = state_q != IDLE;
        done_d     = 1'b0;
        data_d     = data_q;
        status_d   = status_q;
        opa_d      = opa_q;
        opb_d      = opb_q;
        sgn_d      = sgn_q;
        sub_d      = sub_q;
        inx_d      = inx_q;
        spc_d      = spc_q;
        spc_data_d = spc_data_q;
        spc_st_d   = spc_st_q;
        exp_d      = exp_q;
        dif_d      = dif_q;
        big_d      = big_q;
        sml_d      = sml_q;
        acc_d      = acc_q;
        case (state_q)
            IDLE: begin
                if (start_in) begin
                    opa_d = Op_A_in;
                    opb_d = Op_B_in;
                end
            end
            UNPACK: begin
                sgn_d      = big_op[31];
                sub_d      = big_op[31] ^ sml_op[31];
                exp_d      = {2'b0, big_op[30:21]};
                dif_d      = big_op[30:21] - sml_op[30:21];
                big_d      = {1'b1, big_op[20:0], 3'b0};
                sml_d      = {1'b1, sml_op[20:0], 3'b0};
                // big exponent 0 implies both are zero; small exponent 0 passes big through
                spc_d      = big_op[30:21] == 10'h3FF || sml_op[30:21] == 10'h0;
                spc_data_d = big_op[30:21] == 10'h3FF ? {big_op[31], 10'h3FF, 21'h0} :
                             big_op[30:21] == 10'h0 ? 32'h0 : big_op;
                spc_st_d   = big_op[30:21] == 10'h3FF ? OVERFLOW : EXACT;
            end
            ALIGN: sml_d = dif_q >= 10'd25 ? 25'd1 : shf[49:25] | {24'b0, |shf[24:0]};
            ADD: acc_d = sub_q ? {1'b0, big_q} - {1'b0, sml_q} : {1'b0, big_q} + {1'b0, sml_q};
            NORM: begin
                if (acc_q[25]) begin
                    acc_d = {1'b0, acc_q[25:2], acc_q[1] | acc_q[0]};
                    exp_d = exp_q + 12'sd1;
                end else begin
                    acc_d = {1'b0, acc_q[24:0] << lz};
                    exp_d = exp_q - $signed({7'b0, lz});
                    if (acc_q == 26'd0 && !spc_q) begin
                        spc_d      = 1'b1;
                        spc_data_d = 32'h0;
                        spc_st_d   = EXACT;
                    end
                end
            end
            ROUND: begin
                inx_d = |acc_q[2:0];
                acc_d = {4'b0, rnd[22] ? rnd[22:1] : rnd[21:0]};
                exp_d = exp_q + $signed({11'b0, rnd[22]});
            end
            DONE: begin
                done_d   = 1'b1;
                data_d   = spc_q ? spc_data_q :
                           exp_q >= 12'sd1023 ? {sgn_q, 10'h3FF, 21'h0} :
                           exp_q <= 12'sd0 ? 32'h0 : {sgn_q, exp_q[9:0], acc_q[20:0]};
                status_d = spc_q ? spc_st_q :
                           exp_q >= 12'sd1023 ? OVERFLOW :
                           exp_q <= 12'sd0 ? UNDERFLOW : inx_q ? INEXACT : EXACT;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock_100Khz or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            data_q     <= 32'h0;
            status_q   <= EXACT;
            opa_q      <= 32'h0;
            opb_q      <= 32'h0;
            sgn_q      <= 1'b0;
            sub_q      <= 1'b0;
            inx_q      <= 1'b0;
            spc_q      <= 1'b0;
            spc_data_q <= 32'h0;
            spc_st_q   <= EXACT;
            exp_q      <= 12'sd0;
            dif_q      <= 10'd0;
            big_q      <= 25'd0;
            sml_q      <= 25'd0;
            acc_q      <= 26'd0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            data_q     <= data_d;
            status_q   <= status_d;
            opa_q      <= opa_d;
            opb_q      <= opb_d;
            sgn_q      <= sgn_d;
            sub_q      <= sub_d;
            inx_q      <= inx_d;
            spc_q      <= spc_d;
            spc_data_q <= spc_data_d;
            spc_st_q   <= spc_st_d;
            exp_q      <= exp_d;
            dif_q      <= dif_d;
            big_q      <= big_d;
            sml_q      <= sml_d;
            acc_q      <= acc_d;
        end
    end

    assign busy_out   = busy_q;
    assign done_out   = done_q;
    assign data_out   = data_q;
    assign status_out = status_q;
endmodule

// File: tb/tb_fpu_add_seq.sv
// tb_fpu_add_seq: scoreboard bench for fpu_add_seq against an exact-arithmetic reference model.
module tb_fpu_add_seq;
    localparam logic [3:0] OVF = 4'd0, UNF = 4'd1, EXA = 4'd2, INX = 4'd3;
`ifdef FPU_ROUND_NEAREST_EN
    localparam logic [31:0] TIE_RES = 32'h3FE00002;
`else
    localparam logic [31:0] TIE_RES = 32'h3FE00001;
`endif

    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [31:0] a = 32'h0, b = 32'h0;
    logic        busy, done;
    logic [31:0] data;
    logic [3:0]  status;

    fpu_add_seq dut (
        .clock_100Khz(clk), .reset(rst_n), .start_in(start), .Op_A_in(a), .Op_B_in(b),
        .busy_out(busy), .done_out(done), .data_out(data), .status_out(status)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  st;
        int          due;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_cmp = 0, n_bad = 0;
    logic prev_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Exact integer arithmetic: the big significand sits at bit 61; anything far below is an epsilon.
    function automatic logic [35:0] model(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] bg, sm;
        logic [63:0] bv, sv, r, m, rem, half;
        int eb, es, d, p, e;
        bg = (x[30:0] >= y[30:0]) ? x : y;
        sm = (x[30:0] >= y[30:0]) ? y : x;
        eb = int'(bg[30:21]);
        es = int'(sm[30:21]);
        if (eb == 1023) return {OVF, bg[31], 10'h3FF, 21'h0};
        if (eb == 0) return {EXA, 32'h0};
        if (es == 0) return {EXA, bg};
        d  = eb - es;
        bv = {42'h0, 1'b1, bg[20:0]} << 40;
        sv = d > 40 ? 64'd1 : ({42'h0, 1'b1, sm[20:0]} << 40) >> d;
        r  = (bg[31] != sm[31]) ? bv - sv : bv + sv;
        if (r == 64'd0) return {EXA, 32'h0};
        p = 63;
        while (r[p] == 1'b0) p--;
        e    = eb + p - 61;
        m    = r >> (p - 21);
        rem  = r & ((64'd1 << (p - 21)) - 64'd1);
        half = 64'd1 << (p - 22);
`ifdef FPU_ROUND_NEAREST_EN
        if (rem > half || (rem == half && m[0])) m = m + 64'd1;
        if (m[22]) begin
            m = m >> 1;
            e++;
        end
`endif
        if (e >= 1023) return {OVF, bg[31], 10'h3FF, 21'h0};
        if (e <= 0) return {UNF, 32'h0};
        return {(rem != 64'd0) ? INX : EXA, bg[31], 10'(e), m[20:0]};
    endfunction

    always @(negedge clk) begin
        if (rst_n && done) begin
            check("done_pulse", {31'b0, prev_done}, 32'h0);
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got data %h status %0d, want no done", data, status);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("data", data, e.data);
                check("status", {28'b0, status}, {28'b0, e.st});
                check("latency", cyc, e.due);
            end
        end
        prev_done = done;
    end

    task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic [35:0] want,
                         input bit poke);
        exp_t e;
        @(negedge clk);
        a = x;
        b = y;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        e.data = want[31:0];
        e.st = want[35:32];
        e.due = cyc + 6;
        q.push_back(e);
        for (int k = 0; k < 5; k++) begin
            a = $urandom;
            b = $urandom;
            @(negedge clk);
            start = poke && k == 1;
        end
        start = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && q.size() > 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d pending results, want 0", q.size());
            q.delete();
        end
    endtask

    function automatic logic [31:0] rnd_op(input logic [31:0] ref_op);
        logic [31:0] r;
        int e, mode;
        r = $urandom;
        mode = int'($urandom_range(0, 9));
        if (mode < 5) begin
            e = int'(ref_op[30:21]) + int'($urandom_range(0, 60)) - 30;
            e = e < 1 ? 1 : e > 1022 ? 1022 : e;
            r[30:21] = 10'(e);
        end else if (mode == 5) r[30:21] = 10'h0;
        else if (mode == 6) r[30:21] = 10'h3FF;
        else if (mode == 7) r = ref_op ^ 32'h8000_0000;
        else if (mode == 8) r = {~ref_op[31], ref_op[30:21], r[20:0]};
        return r;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] x, y;
        exp_t e;
        int acc, seen;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_done", {31'b0, done}, 32'h0);
        check("rst_data", data, 32'h0);
        check("rst_status", {28'b0, status}, {28'b0, EXA});
        rst_n = 1'b1;
        @(negedge clk);

        a = 32'h4000_0000;
        b = 32'h3FE0_0000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        e.data = 32'h4010_0000;
        e.st = EXA;
        e.due = cyc + 6;
        q.push_back(e);
        check("busy_n0", {31'b0, busy}, 32'h0);
        @(negedge clk);
        check("busy_n1", {31'b0, busy}, 32'h1);
        repeat (5) @(negedge clk);
        check("busy_n6", {31'b0, busy}, 32'h1);
        @(negedge clk);
        check("busy_n7", {31'b0, busy}, 32'h0);

        issue(32'h4040_0000, 32'hC040_0000, {EXA, 32'h0000_0000}, 1'b0);
        issue(32'h4024_0000, 32'h4024_0000, {EXA, 32'h4044_0000}, 1'b1);
        issue(32'h4120_0000, 32'h3FE0_0000, {EXA, 32'h4120_0800}, 1'b0);
        issue(32'h3FE0_0001, 32'h3D40_0000, {EXA, 32'h3FE0_0002}, 1'b0);
        issue(32'h7FDF_FFFF, 32'h7FDF_FFFF, {OVF, 32'h7FE0_0000}, 1'b0);
        issue(32'h7FE0_0000, 32'hFFE0_0000, {OVF, 32'h7FE0_0000}, 1'b0);
        issue(32'h0000_0000, 32'hBFE0_0000, {EXA, 32'hBFE0_0000}, 1'b0);
        issue(32'h8000_0000, 32'h8000_0000, {EXA, 32'h0000_0000}, 1'b0);
        issue(32'h0030_0000, 32'h8020_0000, {UNF, 32'h0000_0000}, 1'b0);
        issue(32'h3FE0_0001, 32'h3D20_0000, {INX, TIE_RES}, 1'b0);

        for (int i = 0; i < 300; i++) begin
            x = $urandom;
            if ($urandom_range(0, 4) == 0) x[30:21] = 10'($urandom_range(1, 30));
            else if ($urandom_range(0, 4) == 0) x[30:21] = 10'($urandom_range(1000, 1022));
            y = rnd_op(x);
            if ($urandom_range(0, 1) == 1) issue(x, y, model(x, y), $urandom_range(0, 3) == 0);
            else issue(y, x, model(y, x), $urandom_range(0, 3) == 0);
        end
        drain();

        x = 32'h3FE0_0001;
        y = 32'h3D20_0000;
        @(negedge clk);
        a = x;
        b = y;
        start = 1'b1;
        @(negedge clk);
        acc = cyc;
        for (int k = 0; k < 3; k++) begin
            e.data = TIE_RES;
            e.st = INX;
            e.due = acc + 6 + 7 * k;
            q.push_back(e);
        end
        repeat (14) @(negedge clk);
        start = 1'b0;
        drain();

        @(negedge clk);
        a = 32'h4000_0000;
        b = 32'h3FE0_0000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        a = 32'h7FDF_FFFF;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", {31'b0, busy}, 32'h0);
        check("abort_done", {31'b0, done}, 32'h0);
        check("abort_data", data, 32'h0);
        check("abort_status", {28'b0, status}, {28'b0, EXA});
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) seen++;
        end
        check("abort_no_done", seen, 0);
        issue(32'h4000_0000, 32'h3FE0_0000, {EXA, 32'h4010_0000}, 1'b0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
